// File: rtl/tt6581_spi_master.sv
// SPI mode-0 master for the tt6581 register port: one 16-bit {rw, addr, data} frame per request,
// with the MISO byte shifted in during the data half returned on a single-cycle response pulse.
module tt6581_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned TAIL_W = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TAIL_W-1:0]   frame_q, frame_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                div_last;

    assign div_last = (div_q == CNT_W'(CLK_DIV - 1));

    // Next-state and next-output computation; frame_q holds the bits still to be sent after mosi_q.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    frame_d = {req_addr_i, req_wdata_i};
                    mosi_d  = req_write_i;
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    div_d   = '0;
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], miso_i};
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + CNT_W'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: advance MOSI unless this ends the 16th period.
                        sclk_d = 1'b0;
                        if (bit_q == BIT_W'(15)) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            mosi_d  = frame_q[TAIL_W-1];
                            frame_d = {frame_q[TAIL_W-2:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso_i};
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    div_d       = '0;
                    cs_d        = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rx_q;
                    state_d     = S_GAP;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (div_q == CNT_W'(CS_GAP - 1)) begin
                    div_d   = '0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                ready_d = 1'b1;
                div_d   = '0;
            end
        endcase

        busy_d = ~ready_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign cs_o        = cs_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;

endmodule

// File: tb/tb_tt6581_spi_master.sv
// Bench for tt6581_spi_master: mode-0 slave model, frame scoreboard, and a CLK_DIV=255 instance
// for slow phase timing.
module tb_tt6581_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, req_write, miso;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid, busy, sclk, cs, mosi;
    logic [7:0] rsp_rdata;

    logic       s_valid, s_write, s_miso;
    logic [6:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_ready, s_rsp_valid, s_busy, s_sclk, s_cs, s_mosi;
    logic [7:0] s_rdata;

    tt6581_spi_master #(.CLK_DIV(4), .CS_GAP(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
        .sclk_o(sclk), .cs_o(cs), .mosi_o(mosi), .miso_i(miso)
    );

    tt6581_spi_master #(.CLK_DIV(255), .CS_GAP(2)) dut_slow (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(s_valid), .req_ready_o(s_ready), .req_write_i(s_write),
        .req_addr_i(s_addr), .req_wdata_i(s_wdata),
        .rsp_valid_o(s_rsp_valid), .rsp_rdata_o(s_rdata), .busy_o(s_busy),
        .sclk_o(s_sclk), .cs_o(s_cs), .mosi_o(s_mosi), .miso_i(s_miso)
    );

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] resp;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic [15:0] mosi;
        logic [7:0]  rdata;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          passed = 0;

    logic [15:0] slave_resp = 16'h0000;
    logic [15:0] slave_sh;
    logic [15:0] cur_mosi;
    logic [7:0]  cur_rdata;
    int          accepts = 0;
    int          frames_done = 0;
    int          rsp_pulses = 0;
    int          low_len, rises, high_gap = 0, last_gap = 0;
    logic [15:0] mosi_acc;
    logic        abort = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard push on every accepted request, as seen from the bus side.
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) begin
            sb.push_back(exp_t'{cur_mosi, cur_rdata});
            accepts++;
        end
    end

    // Bus monitor, invariant checks and mode-0 slave (MISO changes after each SCLK fall).
    always @(negedge clk) begin
        exp_t e;
        check("busy_inv", busy, !req_ready);
        if (cs) begin
            check("mosi_idle", mosi, 1'b0);
            check("sclk_idle", sclk, 1'b0);
        end else begin
            check("ready_low", req_ready, 1'b0);
        end
        if (rsp_valid) rsp_pulses++;

        if (!cs && prev_cs) begin
            low_len  = 0;
            rises    = 0;
            mosi_acc = '0;
            last_gap = high_gap;
            slave_sh = slave_resp;
            miso     = slave_sh[15];
        end
        if (!cs) begin
            low_len++;
            if (sclk && !prev_sclk) begin
                rises++;
                mosi_acc = {mosi_acc[14:0], mosi};
            end
            if (!sclk && prev_sclk) begin
                slave_sh = slave_sh << 1;
                miso     = slave_sh[15];
            end
        end else begin
            high_gap = prev_cs ? high_gap + 1 : 1;
        end

        if (cs && !prev_cs) begin
            if (abort) begin
                abort = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (sb.size() == 0) begin
                check("sb_empty_frame", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("frame_mosi", mosi_acc, e.mosi);
                check("cs_low_len", low_len, 132);
                check("sclk_rises", rises, 16);
                check("rsp_valid_at_end", rsp_valid, 1'b1);
                check("rsp_rdata", rsp_rdata, e.rdata);
                frames_done++;
            end
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    // Slow-instance monitor: phase lengths and frame length.
    logic        s_prev_cs = 1'b1, s_prev_sclk = 1'b0, s_done = 1'b0;
    int          s_low_len, s_hi_run, s_lo_run, s_rsp = 0;
    int          hi_min, hi_max, lo_min, lo_max;
    logic [15:0] s_mosi_acc;

    always @(negedge clk) begin
        if (s_rsp_valid) s_rsp++;
        if (!s_cs && s_prev_cs) begin
            s_low_len = 0; s_hi_run = 0; s_lo_run = 0; s_mosi_acc = '0;
            hi_min = 99999; hi_max = 0; lo_min = 99999; lo_max = 0;
        end
        if (!s_cs) begin
            if (s_sclk && !s_prev_sclk) begin
                if (s_lo_run < lo_min) lo_min = s_lo_run;
                if (s_lo_run > lo_max) lo_max = s_lo_run;
                s_lo_run   = 0;
                s_mosi_acc = {s_mosi_acc[14:0], s_mosi};
            end
            if (!s_sclk && s_prev_sclk) begin
                if (s_hi_run < hi_min) hi_min = s_hi_run;
                if (s_hi_run > hi_max) hi_max = s_hi_run;
                s_hi_run = 0;
            end
            s_low_len++;
            if (s_sclk) s_hi_run++;
            else s_lo_run++;
        end
        if (s_cs && !s_prev_cs) begin
            if (s_lo_run < lo_min) lo_min = s_lo_run;
            if (s_lo_run > lo_max) lo_max = s_lo_run;
            s_done = 1'b1;
        end
        s_prev_cs   = s_cs;
        s_prev_sclk = s_sclk;
    end

    task automatic send(input vec_t v);
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("ready_timeout", 32'd0, 32'd1);
        slave_resp = v.resp;
        cur_mosi   = v.exp_mosi;
        cur_rdata  = v.exp_rdata;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(sb.size() == 0 && req_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int start_acc;
        int start_frames;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        miso = 1'b0; cur_mosi = '0; cur_rdata = '0;
        s_valid = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; s_miso = 1'b0;

        vecs[0] = '{1'b1, 7'h05, 8'hA3, 16'h0000, 16'h85A3, 8'h00};
        vecs[1] = '{1'b0, 7'h1B, 8'h00, 16'h125C, 16'h1B00, 8'h5C};
        vecs[2] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF};
        vecs[3] = '{1'b0, 7'h00, 8'h3C, 16'h8001, 16'h003C, 8'h01};
        vecs[4] = '{1'b1, 7'h2A, 8'h55, 16'h00AA, 16'hAA55, 8'hAA};

        repeat (2) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_slow_cs", s_cs, 1'b1);
        check("rst_slow_busy", s_busy, 1'b0);
        check("rst_slow_rdata", s_rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i]);
            wait_idle();
        end

        // Back-to-back with request held high through GAP.
        slave_resp = 16'h00C3; cur_mosi = 16'hC211; cur_rdata = 8'hC3;
        req_write = 1'b1; req_addr = 7'h42; req_wdata = 8'h11; req_valid = 1'b1;
        start_acc = accepts;
        n = 0;
        while (accepts < start_acc + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", accepts, start_acc + 2);
        wait_idle();
        check("b2b_gap", last_gap, 3);

        // Reset during SHIFT bit 7 aborts the frame.
        send('{1'b1, 7'h05, 8'hA3, 16'h0000, 16'h85A3, 8'h00});
        n = 0;
        while (!(rises == 8 && sclk) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("bit7_timeout", 32'd0, 32'd1);
        start_frames = frames_done;
        abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rdata", rsp_rdata, 8'h00);
        repeat (40) @(negedge clk);
        check("abort_no_rsp", rsp_pulses, frames_done);
        check("abort_no_frame", frames_done, start_frames);
        send('{1'b0, 7'h1B, 8'h00, 16'h125C, 16'h1B00, 8'h5C});
        wait_idle();

        // Request pulsed while busy is ignored.
        start_frames = frames_done;
        send('{1'b1, 7'h10, 8'h77, 16'h0000, 16'h9077, 8'h00});
        repeat (10) @(negedge clk);
        req_write = 1'b0; req_addr = 7'h7F; req_wdata = 8'h00; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        repeat (200) @(negedge clk);
        check("busy_ignore_frames", frames_done, start_frames + 1);
        check("rsp_count", rsp_pulses, frames_done);

        // Slow instance: CLK_DIV=255 write.
        s_write = 1'b1; s_addr = 7'h33; s_wdata = 8'hC4; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!s_done && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) check("slow_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        check("slow_cs_low", s_low_len, 8415);
        check("slow_hi_min", hi_min, 255);
        check("slow_hi_max", hi_max, 255);
        check("slow_lo_min", lo_min, 255);
        check("slow_lo_max", lo_max, 255);
        check("slow_mosi", s_mosi_acc, 16'hB3C4);
        check("slow_rsp", s_rsp, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
